// File: rtl/prim_share_split_pkg.sv
// Shared types and helpers for the share splitter.
// Holds the FSM state encoding, a population count and the circular
// remainder-distribution helpers used by prim_share_split.
// The helpers work on a fixed maximum vector width; callers zero-extend
// their enable masks and pass the real destination count.
package prim_share_split_pkg;

    // Upper bound on destinations supported by the helper functions.
    localparam int MaxDst = 32;

    localparam logic [MaxDst-1:0] OneHot0 = MaxDst'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        ASSIGN = 2'd2,
        RESP   = 2'd3
    } split_state_e;

    // Number of set bits in a mask.
    function automatic int popcount(input logic [MaxDst-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MaxDst; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    // Mask of destinations that receive one extra unit: walking enabled
    // destinations circularly from 'start', the first 'r' of them are marked.
    function automatic logic [MaxDst-1:0] rr_plus_mask(
        input logic [MaxDst-1:0] en,
        input int                num_dst,
        input int                start,
        input int                r
    );
        logic [MaxDst-1:0] mask;
        int                given;
        int                idx;
        mask  = '0;
        given = 0;
        idx   = start;
        for (int k = 0; k < MaxDst; k++) begin
            if (k < num_dst) begin
                if ((((en >> idx) & OneHot0) != '0) && (given < r)) begin
                    mask  = mask | (OneHot0 << idx);
                    given = given + 1;
                end
                idx = (idx + 1 >= num_dst) ? 0 : idx + 1;
            end
        end
        return mask;
    endfunction

    // Pointer position just past the last extra-unit recipient of the same
    // walk; returns 'start' unchanged when no extra units are handed out.
    function automatic int rr_next_ptr(
        input logic [MaxDst-1:0] en,
        input int                num_dst,
        input int                start,
        input int                r
    );
        int given;
        int idx;
        int nxt;
        given = 0;
        idx   = start;
        nxt   = start;
        for (int k = 0; k < MaxDst; k++) begin
            if (k < num_dst) begin
                if ((((en >> idx) & OneHot0) != '0) && (given < r)) begin
                    given = given + 1;
                    nxt   = (idx + 1 >= num_dst) ? 0 : idx + 1;
                end
                idx = (idx + 1 >= num_dst) ? 0 : idx + 1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/prim_share_split_div.sv
// Iterative restoring divider: one quotient bit per clock.
// The first step is taken on the start edge using the live inputs, so the
// final quotient/remainder are registered Width edges after start and the
// done pulse is high during the cycle in which they first become valid.
// Results stay held until the next start.
module prim_share_split_div #(
    parameter int Width = 8,
    parameter int CntW  = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    input  logic [Width-1:0] dividend,
    input  logic [CntW-1:0]  divisor,
    output logic             done,
    output logic [Width-1:0] quotient,
    output logic [CntW-1:0]  remainder
);

    localparam int StepW = $clog2(Width + 1);
    localparam logic [StepW-1:0] StepsAfterStart = StepW'(Width - 1);

    logic [CntW-1:0]  rem_reg, rem_next;
    logic [Width-1:0] quo_reg, quo_next;
    logic [CntW-1:0]  dsr_reg;
    logic [StepW-1:0] steps_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CntW-1:0]  src_rem;
    logic [Width-1:0] src_quo;
    logic [CntW-1:0]  src_dsr;
    logic [CntW:0]    trial;
    logic             q_bit;

    // One restoring step, fed from the inputs on start, else from the state.
    always_comb begin
        src_rem = start ? '0 : rem_reg;
        src_quo = start ? dividend : quo_reg;
        src_dsr = start ? divisor : dsr_reg;
        trial   = {src_rem, src_quo[Width-1]};
        q_bit   = 1'b0;
        rem_next = trial[CntW-1:0];
        if (trial >= {1'b0, src_dsr}) begin
            q_bit    = 1'b1;
            rem_next = CntW'(trial - {1'b0, src_dsr});
        end
        quo_next = (src_quo << 1) | Width'(q_bit);
    end

    // Step sequencing: load on start, iterate while busy, pulse done at the end.
    always_ff @(posedge clk) begin
        if (srst) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            dsr_reg   <= '0;
            steps_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rem_reg   <= rem_next;
                quo_reg   <= quo_next;
                dsr_reg   <= divisor;
                steps_reg <= StepsAfterStart;
                busy_reg  <= (Width > 1);
                done_reg  <= (Width == 1);
            end else if (busy_reg) begin
                rem_reg   <= rem_next;
                quo_reg   <= quo_next;
                steps_reg <= steps_reg - StepW'(1);
                if (steps_reg == StepW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done      = done_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/prim_share_split.sv
// Share splitter: divides one total across the enabled destinations so the
// shares sum exactly to the total. Base share is total / count; the remainder
// is handed out as single extra units.
// Optional feature macro PRIM_SHARE_SPLIT_RR_EN: when defined, extra units
// start at a round-robin pointer that advances past the last recipient; when
// undefined, extra units always go to the lowest-indexed enabled destinations.
module prim_share_split
    import prim_share_split_pkg::*;
#(
    parameter int NumDst = 4,
    parameter int Width  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [Width-1:0]        total_i,
    input  logic [NumDst-1:0]       en_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [NumDst*Width-1:0] shares_o,
    output logic [NumDst-1:0]       share_valid_o,
    output logic                    rsp_any_o,
    output logic                    busy_o
);

    localparam int CntW = $clog2(NumDst + 1);
    localparam int PtrW = (NumDst > 1) ? $clog2(NumDst) : 1;

    if (NumDst < 2 || NumDst > MaxDst || (1 << Width) < NumDst) begin : g_bad_params
        $error("prim_share_split: unsupported NumDst/Width combination");
    end

    split_state_e     state_reg;
    logic             req_ready_reg;
    logic             busy_reg;
    logic             rsp_valid_reg;
    logic             rsp_any_reg;
    logic [NumDst-1:0] en_reg;
    logic [NumDst-1:0] share_valid_reg;
    logic [Width-1:0] shares_reg [NumDst];
    logic [Width-1:0] share_calc [NumDst];

    logic             req_fire;
    logic [CntW-1:0]  req_cnt;
    logic             div_start;
    logic             div_done;
    logic [Width-1:0] div_quo;
    logic [CntW-1:0]  div_rem;
    logic [NumDst-1:0] plus_mask;
    logic [31:0]      rr_start_ext;

    assign req_fire  = req_valid_i & req_ready_reg;
    assign req_cnt   = CntW'(popcount(MaxDst'(en_i)));
    assign div_start = req_fire & (req_cnt != '0);

    prim_share_split_div #(
        .Width (Width),
        .CntW  (CntW)
    ) u_div (
        .clk       (clk_i),
        .srst      (rst_i),
        .start     (div_start),
        .dividend  (total_i),
        .divisor   (req_cnt),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

`ifdef PRIM_SHARE_SPLIT_RR_EN
    logic [PtrW-1:0] rr_ptr_reg;
    logic [PtrW-1:0] rr_pend_reg;
    logic [PtrW-1:0] rr_next_calc;

    assign rr_start_ext = 32'(rr_ptr_reg);
    assign rr_next_calc = PtrW'(rr_next_ptr(MaxDst'(en_reg), NumDst, rr_start_ext, 32'(div_rem)));

    // Pointer bookkeeping: stage the new position while assigning, commit it
    // only when the response is actually consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg  <= '0;
            rr_pend_reg <= '0;
        end else begin
            if (state_reg == ASSIGN) begin
                rr_pend_reg <= rr_next_calc;
            end else if (req_fire && (req_cnt == '0)) begin
                rr_pend_reg <= rr_ptr_reg;
            end
            if ((state_reg == RESP) && rsp_ready_i) begin
                rr_ptr_reg <= rr_pend_reg;
            end
        end
    end
`else
    assign rr_start_ext = '0;
`endif

    assign plus_mask = NumDst'(rr_plus_mask(MaxDst'(en_reg), NumDst, rr_start_ext, 32'(div_rem)));

    for (genvar gi = 0; gi < NumDst; gi++) begin : g_dst
        assign share_calc[gi] = en_reg[gi] ? (div_quo + Width'(plus_mask[gi])) : '0;
        assign shares_o[gi*Width +: Width] = shares_reg[gi];
    end

    // Main control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_any_reg     <= 1'b0;
            en_reg          <= '0;
            share_valid_reg <= '0;
            for (int i = 0; i < NumDst; i++) begin
                shares_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_fire) begin
                        en_reg        <= en_i;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (req_cnt == '0) begin
                            // Nothing enabled: answer immediately with zeros.
                            state_reg       <= RESP;
                            rsp_valid_reg   <= 1'b1;
                            rsp_any_reg     <= 1'b0;
                            share_valid_reg <= '0;
                            for (int i = 0; i < NumDst; i++) begin
                                shares_reg[i] <= '0;
                            end
                        end else begin
                            state_reg <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state_reg <= ASSIGN;
                    end
                end
                ASSIGN: begin
                    for (int i = 0; i < NumDst; i++) begin
                        shares_reg[i] <= share_calc[i];
                    end
                    share_valid_reg <= en_reg;
                    rsp_any_reg     <= 1'b1;
                    rsp_valid_reg   <= 1'b1;
                    state_reg       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_reg;
    assign rsp_valid_o   = rsp_valid_reg;
    assign share_valid_o = share_valid_reg;
    assign rsp_any_o     = rsp_any_reg;
    assign busy_o        = busy_reg;

endmodule

// File: tb/tb_prim_share_split.sv
// Self-checking bench for prim_share_split (NumDst=4, Width=8).
// Expected shares come from a queue-based model of the splitting rule;
// works with or without PRIM_SHARE_SPLIT_RR_EN.
module tb_prim_share_split;

    localparam int NumDst = 4;
    localparam int Width  = 8;
`ifdef PRIM_SHARE_SPLIT_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [7:0]  total_i = '0;
    logic [3:0]  en_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] shares_o;
    logic [3:0]  share_valid_o;
    logic        rsp_any_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int model_rr = 0;

    always #5 clk = ~clk;

    prim_share_split #(
        .NumDst (NumDst),
        .Width  (Width)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .total_i       (total_i),
        .en_i          (en_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .shares_o      (shares_o),
        .share_valid_o (share_valid_o),
        .rsp_any_o     (rsp_any_o),
        .busy_o        (busy_o)
    );

    // Reference: enabled destinations listed circularly from the start pointer;
    // each gets total/cnt, the first total%cnt of them one more.
    function automatic logic [31:0] model_shares(input logic [7:0] total, input logic [3:0] en,
                                                 input int rr_start, output int rr_after);
        int order[$];
        int q;
        int r;
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            if (en[(rr_start + k) % 4]) order.push_back((rr_start + k) % 4);
        end
        rr_after = rr_start;
        if (order.size() == 0) return res;
        q = int'(total) / order.size();
        r = int'(total) % order.size();
        for (int j = 0; j < order.size(); j++) begin
            res[order[j]*8 +: 8] = 8'(q + ((j < r) ? 1 : 0));
        end
        if (r > 0) rr_after = (order[r-1] + 1) % 4;
        return res;
    endfunction

    // Present a request and wait (bounded) for its handshake; ends at the
    // falling edge of the cycle after the handshake.
    task automatic issue_req(input logic [7:0] total, input logic [3:0] en, output bit ok);
        req_valid_i = 1'b1;
        total_i = total;
        en_i = en;
        for (int i = 0; i < 30 && !req_ready_o; i++) @(negedge clk);
        ok = req_ready_o;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Count cycles since the handshake until rsp_valid_o (bounded).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Full transaction: request, wait, capture, optional back-pressure, release.
    task automatic run_one(input logic [7:0] total, input logic [3:0] en, input int hold,
                           output logic [31:0] sh, output logic [3:0] sv, output logic any,
                           output int lat, output bit ok);
        issue_req(total, en, ok);
        wait_rsp(lat);
        sh = shares_o;
        sv = share_valid_o;
        any = rsp_any_o;
        repeat (hold) @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid_o); end
        checks++; if (shares_o !== 32'h0) begin errors++; $display("FAIL reset_shares got=%h exp=0", shares_o); end
        checks++; if (share_valid_o !== 4'h0) begin errors++; $display("FAIL reset_share_valid got=%b exp=0", share_valid_o); end
        checks++; if (rsp_any_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_any got=%0b exp=0", rsp_any_o); end
        rst_i = 1'b0;
        model_rr = 0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_directed();
        logic [7:0]  tot_t [6] = '{8'd10, 8'd10, 8'd7, 8'd5, 8'd255, 8'd10};
        logic [3:0]  en_t  [6] = '{4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0010, 4'b1111};
        logic [31:0] cst_t [6];
        logic [31:0] sh, exp_sh;
        logic [3:0]  sv;
        logic        any;
        int          lat, rr_after, exp_lat;
        bit          ok;
        cst_t[0] = 32'h02020303;
        cst_t[1] = RrEn ? 32'h03030202 : 32'h02020303;
        cst_t[2] = 32'h00030004;
        cst_t[3] = 32'h00000000;
        cst_t[4] = 32'h0000FF00;
        cst_t[5] = RrEn ? 32'h02030302 : 32'h02020303;
        for (int t = 0; t < 6; t++) begin
            exp_sh = model_shares(tot_t[t], en_t[t], RrEn ? model_rr : 0, rr_after);
            exp_lat = (en_t[t] == 4'b0) ? 1 : Width + 2;
            run_one(tot_t[t], en_t[t], 0, sh, sv, any, lat, ok);
            checks++; if (!ok) begin errors++; $display("FAIL dir%0d_req_accept got=0 exp=1", t); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", t, lat, exp_lat); end
            checks++; if (sh !== cst_t[t]) begin errors++; $display("FAIL dir%0d_shares_const got=%h exp=%h", t, sh, cst_t[t]); end
            checks++; if (sh !== exp_sh) begin errors++; $display("FAIL dir%0d_shares_model got=%h exp=%h", t, sh, exp_sh); end
            checks++; if (sv !== en_t[t]) begin errors++; $display("FAIL dir%0d_share_valid got=%b exp=%b", t, sv, en_t[t]); end
            checks++; if (any !== (en_t[t] != 4'b0)) begin errors++; $display("FAIL dir%0d_rsp_any got=%0b exp=%0b", t, any, en_t[t] != 4'b0); end
            if (RrEn) model_rr = rr_after;
            $display("directed %0d: total=%0d en=%b shares=%h lat=%0d", t, tot_t[t], en_t[t], sh, lat);
        end
    endtask

    task automatic test_hold();
        logic [31:0] exp_sh, first;
        int          lat, rr_after;
        bit          ok;
        exp_sh = model_shares(8'd23, 4'b1011, RrEn ? model_rr : 0, rr_after);
        issue_req(8'd23, 4'b1011, ok);
        wait_rsp(lat);
        first = shares_o;
        checks++; if (first !== exp_sh) begin errors++; $display("FAIL hold_shares got=%h exp=%h", first, exp_sh); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (shares_o !== first || rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || share_valid_o !== 4'b1011) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d got shares=%h valid=%0b ready=%0b sv=%b exp shares=%h valid=1 ready=0 sv=1011",
                         c, shares_o, rsp_valid_o, req_ready_o, share_valid_o, first);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL hold_release got busy=%0b ready=%0b exp busy=0 ready=1", busy_o, req_ready_o); end
        if (RrEn) model_rr = rr_after;
        $display("hold: shares=%h held 5 cycles", first);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a, exp_b, sh;
        int          lat_a, lat_b, rr_after;
        bit          ok;
        exp_a = model_shares(8'd14, 4'b1110, RrEn ? model_rr : 0, rr_after);
        issue_req(8'd14, 4'b1110, ok);
        wait_rsp(lat_a);
        checks++; if (shares_o !== exp_a) begin errors++; $display("FAIL b2b_a_shares got=%h exp=%h", shares_o, exp_a); end
        if (RrEn) model_rr = rr_after;
        exp_b = model_shares(8'd6, 4'b1001, RrEn ? model_rr : 0, rr_after);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        total_i = 8'd6;
        en_i = 4'b1001;
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_on_rsp_hs got=%0b exp=0", req_ready_o); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_after_hs got ready=%0b valid=%0b exp ready=1 valid=0", req_ready_o, rsp_valid_o); end
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_b_busy got=%0b exp=1", busy_o); end
        wait_rsp(lat_b);
        sh = shares_o;
        checks++; if (lat_b != Width + 2) begin errors++; $display("FAIL b2b_b_latency got=%0d exp=%0d", lat_b, Width + 2); end
        checks++; if (sh !== exp_b) begin errors++; $display("FAIL b2b_b_shares got=%h exp=%h", sh, exp_b); end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        if (RrEn) model_rr = rr_after;
        $display("back_to_back: a=%h b=%h lat_b=%0d", exp_a, sh, lat_b);
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] sh, exp_sh;
        logic [3:0]  sv;
        logic        any;
        int          lat, rr_after;
        bit          ok;
        exp_sh = model_shares(8'd10, 4'b1111, RrEn ? model_rr : 0, rr_after);
        run_one(8'd10, 4'b1111, 0, sh, sv, any, lat, ok);
        checks++; if (sh !== exp_sh) begin errors++; $display("FAIL rstdiv_pre_shares got=%h exp=%h", sh, exp_sh); end
        issue_req(8'd200, 4'b1011, ok);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_rr = 0;
        checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++; $display("FAIL rstdiv_idle got busy=%0b valid=%0b ready=%0b exp busy=0 valid=0 ready=1", busy_o, rsp_valid_o, req_ready_o);
        end
        run_one(8'd9, 4'b1111, 0, sh, sv, any, lat, ok);
        checks++; if (sh !== 32'h02020203) begin errors++; $display("FAIL rstdiv_post_shares got=%h exp=02020203", sh); end
        checks++; if (lat != Width + 2) begin errors++; $display("FAIL rstdiv_post_latency got=%0d exp=%0d", lat, Width + 2); end
        if (RrEn) begin
            void'(model_shares(8'd9, 4'b1111, 0, rr_after));
            model_rr = rr_after;
        end
        $display("reset_mid_div: post shares=%h", sh);
    endtask

    task automatic test_random();
        logic [31:0] sh, exp_sh;
        logic [3:0]  sv, en;
        logic [7:0]  tot, sum;
        logic        any;
        int          lat, rr_after, exp_lat;
        bit          ok;
        for (int t = 0; t < 40; t++) begin
            tot = 8'($urandom_range(0, 255));
            en  = 4'($urandom_range(0, 15));
            exp_sh = model_shares(tot, en, RrEn ? model_rr : 0, rr_after);
            exp_lat = (en == 4'b0) ? 1 : Width + 2;
            run_one(tot, en, $urandom_range(0, 3), sh, sv, any, lat, ok);
            sum = '0;
            for (int d = 0; d < 4; d++) if (sv[d]) sum = sum + sh[d*8 +: 8];
            checks++; if (sh !== exp_sh || sv !== en || any !== (en != 4'b0) || lat != exp_lat || !ok) begin
                errors++;
                $display("FAIL rand%0d got shares=%h sv=%b any=%0b lat=%0d exp shares=%h sv=%b any=%0b lat=%0d",
                         t, sh, sv, any, lat, exp_sh, en, en != 4'b0, exp_lat);
            end
            checks++; if (en != 4'b0 && sum !== tot) begin errors++; $display("FAIL rand%0d_sum got=%0d exp=%0d", t, sum, tot); end
            if (RrEn) model_rr = rr_after;
            $display("random %0d: total=%0d en=%b shares=%h lat=%0d", t, tot, en, sh, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
